alu_exec_stage: RTL and testbench

//  Parametrised execute stage: XLEN-wide ALU, branch resolution, and an optional iterative multiplier with a valid/ready input.

---
 rtl/alu_exec_stage_pkg.sv | 33 +++
 rtl/alu_exec_stage_mul.sv | 74 +++++++
 rtl/alu_exec_stage.sv | 205 ++++++++++++++++++++
 tb/tb_alu_exec_stage.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_stage_pkg.sv
// Shared opcode encoding and constants for the execute stage and its multiplier.
package alu_exec_stage_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;
    localparam int   X0    = 0;

    typedef enum logic [4:0] {
        ADDITION       = 5'd0,
        SUBTRACTION    = 5'd1,
        AND_OP         = 5'd2,
        OR_OP          = 5'd3,
        XOR_OP         = 5'd4,
        SLT_OP         = 5'd5,
        SLL_OP         = 5'd6,
        SRL_OP         = 5'd7,
        MULTIPLICATION = 5'd8,
        UNCOND_JUMP    = 5'd9,
        COND_EQ_JUMP   = 5'd10,
        COND_NE_JUMP   = 5'd11,
        COND_LT_JUMP   = 5'd12
    } alu_op_e;

    function automatic logic is_branch_op(input logic [4:0] op);
        logic r;
        case (op)
            UNCOND_JUMP, COND_EQ_JUMP, COND_NE_JUMP, COND_LT_JUMP: r = TRUE;
            default:                                                r = FALSE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_exec_stage_mul.sv
// Shift-add multiplier: one multiplier bit per cycle, low XLEN bits of the product.
module alu_iter_multiplier
    import alu_exec_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            start_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            done_o,
    output logic [XLEN-1:0] product_o
);

    localparam int CW = $clog2(XLEN);

    logic [XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0] mplier_q, mplier_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            run_q, run_d;
    logic [XLEN-1:0] step_acc_s;

    // Next-state of the shift-add datapath
    always_comb begin
        step_acc_s = acc_q + (mplier_q[0] ? mcand_q : {XLEN{1'b0}});
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        run_d      = run_q;
        if (start_i) begin
            mcand_d  = a_i;
            mplier_d = b_i;
            acc_d    = {XLEN{1'b0}};
            cnt_d    = CW'(XLEN - 1);
            run_d    = TRUE;
        end else if (run_q) begin
            acc_d    = step_acc_s;
            mcand_d  = {mcand_q[XLEN-2:0], 1'b0};
            mplier_d = {1'b0, mplier_q[XLEN-1:1]};
            if (cnt_q == {CW{1'b0}}) begin
                run_d = FALSE;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end else begin
            run_d = FALSE;
        end
    end

    // Datapath registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            mcand_q  <= {XLEN{1'b0}};
            mplier_q <= {XLEN{1'b0}};
            acc_q    <= {XLEN{1'b0}};
            cnt_q    <= {CW{1'b0}};
            run_q    <= FALSE;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
        end
    end

    // The final step's sum is the product, so completion is flagged in the last step cycle
    assign done_o    = run_q && (cnt_q == {CW{1'b0}});
    assign product_o = step_acc_s;

endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage: ALU, branch resolution, kill shadow after taken branches and an
// optional iterative multiplier that stalls upstream via in_ready.
module alu_exec_stage
    import alu_exec_stage_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int REG_BITS      = 5,
    parameter int KILL_SLOTS    = 1,
    parameter int MUL_ITERATIVE = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4:0]          alu_operation,
    input  logic [XLEN-1:0]     input1,
    input  logic [XLEN-1:0]     input2,
    input  logic [XLEN-1:0]     branch_dest,
    input  logic [XLEN-1:0]     next_program_counter,
    input  logic                in_dest_register_enable,
    input  logic [REG_BITS-1:0] in_passthrough_dest_register_number,
    output logic                out_valid,
    output logic [XLEN-1:0]     alu_output,
    output logic                out_dest_register_enable,
    output logic [REG_BITS-1:0] out_passthrough_dest_register_number,
    output logic                alu_out_branch_enable,
    output logic [XLEN-1:0]     alu_out_branch_address,
    output logic                busy
);

    localparam int   SHW  = $clog2(XLEN);
    localparam int   KW   = (KILL_SLOTS > 0) ? $clog2(KILL_SLOTS + 1) : 1;
    localparam logic ITER = (MUL_ITERATIVE != 0);

    typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_e;

    state_e              state_q, state_d;
    logic [KW-1:0]       kill_q, kill_d;
    logic                out_valid_q, out_valid_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic                dest_en_q, dest_en_d;
    logic [REG_BITS-1:0] rd_q, rd_d;
    logic                br_en_q, br_en_d;
    logic [XLEN-1:0]     br_addr_q, br_addr_d;
    logic                busy_q, busy_d;
    logic                mul_en_q, mul_en_d;
    logic [REG_BITS-1:0] mul_rd_q, mul_rd_d;

    logic                in_ready_s, accept_s, killed_s, is_mul_s;
    logic [XLEN-1:0]     res_s, target_s, mul_prod_s;
    logic                taken_s, mul_start_s, mul_done_s;

    assign in_ready_s = (state_q == IDLE) && !reset;
    assign accept_s   = in_valid && in_ready_s;
    assign killed_s   = (kill_q != {KW{1'b0}});
    assign is_mul_s   = (alu_operation == MULTIPLICATION);

    // Combinational ALU and branch condition evaluation
    always_comb begin
        res_s    = {XLEN{1'b0}};
        taken_s  = FALSE;
        target_s = {XLEN{1'b0}};
        case (alu_operation)
            ADDITION:       res_s = input1 + input2;
            SUBTRACTION:    res_s = input1 - input2;
            AND_OP:         res_s = input1 & input2;
            OR_OP:          res_s = input1 | input2;
            XOR_OP:         res_s = input1 ^ input2;
            SLT_OP:         res_s = {{(XLEN-1){1'b0}}, ($signed(input1) < $signed(input2))};
            SLL_OP:         res_s = input1 << input2[SHW-1:0];
            SRL_OP:         res_s = input1 >> input2[SHW-1:0];
            MULTIPLICATION: res_s = input1 * input2;
            UNCOND_JUMP: begin
                res_s    = next_program_counter;
                taken_s  = TRUE;
                target_s = input1 + input2;
            end
            COND_EQ_JUMP: begin
                taken_s  = (input1 == input2);
                target_s = branch_dest;
            end
            COND_NE_JUMP: begin
                taken_s  = (input1 != input2);
                target_s = branch_dest;
            end
            COND_LT_JUMP: begin
                taken_s  = ($signed(input1) < $signed(input2));
                target_s = branch_dest;
            end
            default: res_s = {XLEN{1'b0}};
        endcase
    end

    generate
        if (MUL_ITERATIVE != 0) begin : g_iter_mul
            alu_iter_multiplier #(.XLEN(XLEN)) u_mul (
                .clk_i     (clk),
                .reset_i   (reset),
                .start_i   (mul_start_s),
                .a_i       (input1),
                .b_i       (input2),
                .done_o    (mul_done_s),
                .product_o (mul_prod_s)
            );
        end else begin : g_comb_mul
            assign mul_done_s = FALSE;
            assign mul_prod_s = {XLEN{1'b0}};
        end
    endgenerate

    // FSM next state, kill shadow and output register next values
    always_comb begin
        state_d     = state_q;
        kill_d      = kill_q;
        out_valid_d = FALSE;
        result_d    = result_q;
        dest_en_d   = dest_en_q;
        rd_d        = rd_q;
        br_en_d     = FALSE;
        br_addr_d   = br_addr_q;
        mul_en_d    = mul_en_q;
        mul_rd_d    = mul_rd_q;
        mul_start_s = FALSE;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    if (killed_s) begin
                        kill_d = kill_q - KW'(1);
                    end else if (taken_s) begin
                        kill_d = KW'(KILL_SLOTS);
                    end else begin
                        kill_d = kill_q;
                    end
                    if (ITER && is_mul_s && !killed_s) begin
                        state_d     = MUL;
                        mul_start_s = TRUE;
                        mul_en_d    = in_dest_register_enable;
                        mul_rd_d    = in_passthrough_dest_register_number;
                    end else begin
                        out_valid_d = TRUE;
                        result_d    = (killed_s && is_mul_s) ? {XLEN{1'b0}} : res_s;
                        dest_en_d   = in_dest_register_enable && !killed_s;
                        rd_d        = in_passthrough_dest_register_number;
                        br_en_d     = taken_s && !killed_s;
                        br_addr_d   = target_s;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            MUL: begin
                if (mul_done_s) begin
                    state_d     = IDLE;
                    out_valid_d = TRUE;
                    result_d    = mul_prod_s;
                    dest_en_d   = mul_en_q;
                    rd_d        = mul_rd_q;
                end else begin
                    state_d = MUL;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == MUL);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            kill_q      <= {KW{1'b0}};
            out_valid_q <= FALSE;
            result_q    <= {XLEN{1'b0}};
            dest_en_q   <= FALSE;
            rd_q        <= REG_BITS'(X0);
            br_en_q     <= FALSE;
            br_addr_q   <= {XLEN{1'b0}};
            busy_q      <= FALSE;
            mul_en_q    <= FALSE;
            mul_rd_q    <= REG_BITS'(X0);
        end else begin
            state_q     <= state_d;
            kill_q      <= kill_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            dest_en_q   <= dest_en_d;
            rd_q        <= rd_d;
            br_en_q     <= br_en_d;
            br_addr_q   <= br_addr_d;
            busy_q      <= busy_d;
            mul_en_q    <= mul_en_d;
            mul_rd_q    <= mul_rd_d;
        end
    end

    assign in_ready                             = in_ready_s;
    assign out_valid                            = out_valid_q;
    assign alu_output                           = result_q;
    assign out_dest_register_enable             = dest_en_q;
    assign out_passthrough_dest_register_number = rd_q;
    assign alu_out_branch_enable                = br_en_q;
    assign alu_out_branch_address               = br_addr_q;
    assign busy                                 = busy_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench: default-config instance (iterative MUL, 1 kill slot) plus a
// second instance with KILL_SLOTS=2 and a single-cycle multiplier.
module tb_alu_exec_stage;
    import alu_exec_stage_pkg::*;

    localparam int KILL_A = 1;

    logic        clk, reset;
    logic        in_valid, in_ready, in_en, out_valid, out_en, br_en, busy;
    logic [4:0]  alu_operation, in_rd, out_rd;
    logic [31:0] input1, input2, branch_dest, npc, alu_output, br_addr;

    logic        b_in_valid, b_in_ready, b_in_en, b_out_valid, b_out_en, b_br_en, b_busy;
    logic [4:0]  b_alu_operation, b_in_rd, b_out_rd;
    logic [31:0] b_input1, b_input2, b_branch_dest, b_npc, b_alu_output, b_br_addr;

    alu_exec_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .alu_operation(alu_operation), .input1(input1), .input2(input2),
        .branch_dest(branch_dest), .next_program_counter(npc),
        .in_dest_register_enable(in_en), .in_passthrough_dest_register_number(in_rd),
        .out_valid(out_valid), .alu_output(alu_output), .out_dest_register_enable(out_en),
        .out_passthrough_dest_register_number(out_rd), .alu_out_branch_enable(br_en),
        .alu_out_branch_address(br_addr), .busy(busy)
    );

    alu_exec_stage #(.KILL_SLOTS(2), .MUL_ITERATIVE(0)) dut_b (
        .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .alu_operation(b_alu_operation), .input1(b_input1), .input2(b_input2),
        .branch_dest(b_branch_dest), .next_program_counter(b_npc),
        .in_dest_register_enable(b_in_en), .in_passthrough_dest_register_number(b_in_rd),
        .out_valid(b_out_valid), .alu_output(b_alu_output), .out_dest_register_enable(b_out_en),
        .out_passthrough_dest_register_number(b_out_rd), .alu_out_branch_enable(b_br_en),
        .alu_out_branch_address(b_br_addr), .busy(b_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a, b, bd, npc;
        logic        en;
        logic [4:0]  rd;
        logic [31:0] exp_out;
        logic        exp_en, exp_br;
        logic [31:0] exp_addr;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    int m_kill   = 0;
    vec_t tbl[18];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [4:0] op, input logic [31:0] a, b, bd, pc,
                                input logic en, input logic [4:0] rd, input logic [31:0] eo,
                                input logic ee, input logic eb, input logic [31:0] ea);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.bd = bd; v.npc = pc; v.en = en; v.rd = rd;
        v.exp_out = eo; v.exp_en = ee; v.exp_br = eb; v.exp_addr = ea;
        return v;
    endfunction

    // Reference: architectural meaning of each opcode plus the kill shadow rule
    function automatic vec_t model(input vec_t v, input int kill);
        vec_t        r;
        logic [63:0] p;
        bit          taken, killed;
        r = v; taken = 0; killed = (kill > 0);
        r.exp_out = 0; r.exp_addr = 0;
        case (v.op)
            ADDITION:       r.exp_out = v.a + v.b;
            SUBTRACTION:    r.exp_out = v.a - v.b;
            AND_OP:         r.exp_out = v.a & v.b;
            OR_OP:          r.exp_out = v.a | v.b;
            XOR_OP:         r.exp_out = v.a ^ v.b;
            SLT_OP:         r.exp_out = ($signed(v.a) < $signed(v.b)) ? 32'd1 : 32'd0;
            SLL_OP:         r.exp_out = v.a << (v.b % 32);
            SRL_OP:         r.exp_out = v.a >> (v.b % 32);
            MULTIPLICATION: begin p = {32'd0, v.a} * {32'd0, v.b}; r.exp_out = p[31:0]; end
            UNCOND_JUMP:    begin r.exp_out = v.npc; taken = 1; r.exp_addr = v.a + v.b; end
            COND_EQ_JUMP:   begin taken = (v.a == v.b); r.exp_addr = v.bd; end
            COND_NE_JUMP:   begin taken = (v.a != v.b); r.exp_addr = v.bd; end
            COND_LT_JUMP:   begin taken = ($signed(v.a) < $signed(v.b)); r.exp_addr = v.bd; end
            default:        r.exp_out = 0;
        endcase
        if (killed && v.op == MULTIPLICATION) r.exp_out = 0;
        r.exp_en = v.en && !killed;
        r.exp_br = taken && !killed;
        return r;
    endfunction

    task automatic apply(input vec_t v);
        bit killed, bad;
        check("in_ready before issue", in_ready, 1);
        alu_operation = v.op; input1 = v.a; input2 = v.b; branch_dest = v.bd;
        npc = v.npc; in_en = v.en; in_rd = v.rd; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        killed = (m_kill > 0);
        if (killed) m_kill--;
        else if (v.exp_br) m_kill = KILL_A;
        if (v.op == MULTIPLICATION && !killed) begin
            bad = 0;
            for (int k = 0; k < 32; k++) begin
                if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b1) bad = 1;
                in_valid = 1; alu_operation = 5'($urandom_range(0, 12));
                input1 = $urandom; input2 = $urandom;
                @(posedge clk); #1;
            end
            in_valid = 0;
            check("mul stall window", bad, 0);
        end
        check("out_valid", out_valid, 1);
        check("alu_output", alu_output, v.exp_out);
        check("dest_enable", out_en, v.exp_en);
        check("rd passthrough", out_rd, v.rd);
        check("branch_enable", br_en, v.exp_br);
        if (v.exp_br) check("branch_address", br_addr, v.exp_addr);
        check("busy after completion", busy, 0);
    endtask

    task automatic idle();
        in_valid = 0;
        @(posedge clk); #1;
        check("idle out_valid", out_valid, 0);
    endtask

    task automatic b_issue(input logic [4:0] op, input logic [31:0] a, b, pc,
                           input logic en, input logic [4:0] rd);
        b_alu_operation = op; b_input1 = a; b_input2 = b; b_npc = pc;
        b_branch_dest = 32'h0; b_in_en = en; b_in_rd = rd; b_in_valid = 1;
        @(posedge clk); #1;
        b_in_valid = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        bit   bad;
        clk = 0; reset = 1;
        in_valid = 0; alu_operation = 0; input1 = 0; input2 = 0; branch_dest = 0;
        npc = 0; in_en = 0; in_rd = 0;
        b_in_valid = 0; b_alu_operation = 0; b_input1 = 0; b_input2 = 0; b_branch_dest = 0;
        b_npc = 0; b_in_en = 0; b_in_rd = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", in_ready, 0);
        check("reset b in_ready", b_in_ready, 0);
        check("reset out_valid", out_valid, 0);
        check("reset alu_output", alu_output, 0);
        check("reset dest_enable", out_en, 0);
        check("reset rd", out_rd, 0);
        check("reset branch_enable", br_en, 0);
        check("reset branch_address", br_addr, 0);
        check("reset busy", busy, 0);
        reset = 0;

        // Second instance: single-cycle multiply and a two-slot kill shadow
        b_issue(MULTIPLICATION, 32'd1234, 32'd5678, 32'd0, 1'b1, 5'd7);
        check("b mul valid", b_out_valid, 1);
        check("b mul result", b_alu_output, 32'd7006652);
        check("b mul busy", b_busy, 0);
        check("b mul rd", b_out_rd, 7);
        b_issue(UNCOND_JUMP, 32'h40, 32'h4, 32'h24, 1'b1, 5'd1);
        check("b jal result", b_alu_output, 32'h24);
        check("b jal dest_enable", b_out_en, 1);
        check("b jal branch_enable", b_br_en, 1);
        check("b jal target", b_br_addr, 32'h44);
        b_issue(ADDITION, 32'd1, 32'd1, 32'd0, 1'b1, 5'd2);
        check("b kill1 dest_enable", b_out_en, 0);
        check("b kill1 result", b_alu_output, 2);
        b_issue(MULTIPLICATION, 32'd3, 32'd4, 32'd0, 1'b1, 5'd3);
        check("b kill2 mul valid", b_out_valid, 1);
        check("b kill2 mul result", b_alu_output, 0);
        check("b kill2 dest_enable", b_out_en, 0);
        check("b kill2 in_ready", b_in_ready, 1);
        b_issue(ADDITION, 32'd2, 32'd2, 32'd0, 1'b1, 5'd4);
        check("b post-kill dest_enable", b_out_en, 1);
        check("b post-kill result", b_alu_output, 4);
        check("b post-kill branch_enable", b_br_en, 0);

        tbl[0]  = mk(ADDITION,       32'hFFFFFFFF, 32'd1, 0, 0, 1, 5,  32'h0, 1, 0, 0);
        tbl[1]  = mk(MULTIPLICATION, 32'd1234, 32'd5678, 0, 0, 1, 7,   32'd7006652, 1, 0, 0);
        tbl[2]  = mk(COND_EQ_JUMP,   32'd7, 32'd7, 32'h100, 0, 0, 0,   32'h0, 0, 1, 32'h100);
        tbl[3]  = mk(ADDITION,       32'd1, 32'd2, 0, 0, 1, 3,         32'd3, 0, 0, 0);
        tbl[4]  = mk(ADDITION,       32'd4, 32'd5, 0, 0, 1, 4,         32'd9, 1, 0, 0);
        tbl[5]  = mk(UNCOND_JUMP,    32'h40, 32'h4, 0, 32'h24, 1, 1,   32'h24, 1, 1, 32'h44);
        tbl[6]  = mk(MULTIPLICATION, 32'd6, 32'd7, 0, 0, 1, 9,         32'h0, 0, 0, 0);
        tbl[7]  = mk(SLT_OP,         32'hFFFFFFFF, 32'd1, 0, 0, 1, 2,  32'd1, 1, 0, 0);
        tbl[8]  = mk(SRL_OP,         32'h80000000, 32'h21, 0, 0, 1, 2, 32'h40000000, 1, 0, 0);
        tbl[9]  = mk(COND_LT_JUMP,   32'd5, 32'hFFFFFFFF, 32'h200, 0, 0, 0, 32'h0, 0, 0, 0);
        tbl[10] = mk(SUBTRACTION,    32'd3, 32'd5, 0, 0, 1, 10,        32'hFFFFFFFE, 1, 0, 0);
        tbl[11] = mk(SLL_OP,         32'd1, 32'h3F, 0, 0, 1, 11,       32'h80000000, 1, 0, 0);
        tbl[12] = mk(COND_NE_JUMP,   32'd1, 32'd2, 32'h300, 0, 0, 0,   32'h0, 0, 1, 32'h300);
        tbl[13] = mk(COND_EQ_JUMP,   32'd1, 32'd1, 32'h400, 0, 1, 6,   32'h0, 0, 0, 0);
        tbl[14] = mk(XOR_OP,         32'hF0F0, 32'hFF00, 0, 0, 1, 12,  32'h0FF0, 1, 0, 0);
        tbl[15] = mk(5'd31,          32'd5, 32'd6, 0, 0, 0, 13,        32'h0, 0, 0, 0);
        tbl[16] = mk(AND_OP,         32'hFF00FF00, 32'h0FF00FF0, 0, 0, 1, 14, 32'h0F000F00, 1, 0, 0);
        tbl[17] = mk(OR_OP,          32'hFF00FF00, 32'h0FF00FF0, 0, 0, 1, 15, 32'hFFF0FFF0, 1, 0, 0);
        m_kill = 0;
        foreach (tbl[i]) apply(tbl[i]);
        idle();

        // Reset in the middle of an iterative multiply
        alu_operation = MULTIPLICATION; input1 = 32'd99; input2 = 32'd77;
        in_en = 1; in_rd = 5'd8; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (9) @(posedge clk);
        #1;
        check("mid-mul busy", busy, 1);
        reset = 1;
        #1;
        check("in_ready during reset", in_ready, 0);
        @(posedge clk); #1;
        check("post-reset out_valid", out_valid, 0);
        check("post-reset alu_output", alu_output, 0);
        check("post-reset dest_enable", out_en, 0);
        check("post-reset rd", out_rd, 0);
        check("post-reset branch_enable", br_en, 0);
        check("post-reset busy", busy, 0);
        reset = 0; m_kill = 0;
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) bad = 1;
        end
        check("aborted mul never completes", bad, 0);
        v = mk(ADDITION, 32'd2, 32'd3, 0, 0, 1, 5, 0, 0, 0, 0);
        v = model(v, m_kill);
        check("model add 2+3", v.exp_out, 32'd5);
        apply(v);

        // Randomized instruction stream against the reference model
        for (int n = 0; n < 300; n++) begin
            v.op = 5'($urandom_range(0, 14));
            if (v.op == MULTIPLICATION && $urandom_range(0, 2) != 0) v.op = ADDITION;
            v.a   = $urandom;
            v.b   = ($urandom_range(0, 3) == 0) ? v.a : $urandom;
            v.bd  = $urandom; v.npc = $urandom;
            v.en  = 1'($urandom_range(0, 1));
            v.rd  = 5'($urandom_range(0, 31));
            v = model(v, m_kill);
            apply(v);
            if ($urandom_range(0, 4) == 0) idle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
